// File: rtl/gfx_pkg.sv
// gfx_pkg: coordinate width, screen defaults and shared types for the rasteriser output stages.
package gfx_pkg;
    localparam int COORD_W     = 11;
    localparam int DEF_H_RES   = 640;
    localparam int DEF_V_RES   = 480;
    localparam int DEF_COLOR_W = 8;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t                 x;
        coord_t                 y;
        logic [DEF_COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        LS_IDLE,
        LS_PENDING
    } line_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: buffers rasteriser pixels and issues one framebuffer write per pixel.
// Define PIXEL_WRITER_CLIP_EN to drop off-screen pixels and count them in clip_cnt.
module pixel_writer
    import gfx_pkg::*;
#(
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = DEF_COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               plot,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COLOR_W-1:0] color,
    input  logic               line_done_in,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    input  logic               mem_ack,
    output logic               line_done,
    output logic               idle,
    output logic               almost_full,
    output logic               overflow,
    output logic [15:0]        clip_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        coord_t             x;
        coord_t             y;
        logic [COLOR_W-1:0] color;
    } entry_t;

    entry_t             head;
    logic               full, empty, push, pop, push_req, clip, off_screen;
    logic [CNT_W-1:0]   count, count_nx;
    logic               req_q, req_d, idle_q, idle_d, af_q, af_d, ovf_q, ovf_d, ld_q, ld_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] data_q, data_d;
    line_state_t        st_q, st_d;

`ifdef PIXEL_WRITER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
    logic [15:0] clip_q;
    always_ff @(posedge clk) begin
        if (rst) clip_q <= '0;
        else if (clip && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
    end
    assign clip_cnt = clip_q;
`else
    localparam bit CLIP_EN = 1'b0;
    assign clip_cnt = '0;
`endif

    assign off_screen = (int'(x) >= H_RES) || (int'(y) >= V_RES);
    assign clip       = CLIP_EN && plot && off_screen;

    sync_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({x, y, color}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // idle/almost_full are registered from the post-cycle occupancy so they match the state they describe
    always_comb begin
        push_req = plot && !clip;
        pop      = (!req_q || mem_ack) && !empty;
        push     = push_req && (!full || pop);
        count_nx = count + CNT_W'(push) - CNT_W'(pop);
        req_d    = pop || (req_q && !mem_ack);
        addr_d   = pop ? ADDR_W'(32'(head.y) * 32'(H_RES) + 32'(head.x)) : addr_q;
        data_d   = pop ? head.color : data_q;
        idle_d   = (count_nx == '0) && !req_d;
        af_d     = count_nx >= CNT_W'(FIFO_DEPTH - 2);
        ovf_d    = ovf_q || (push_req && !push);
        st_d     = (st_q == LS_IDLE) ? (line_done_in ? LS_PENDING : LS_IDLE)
                                     : (idle_d ? LS_IDLE : LS_PENDING);
        ld_d     = (st_q == LS_PENDING) && idle_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            idle_q <= 1'b1;
            af_q   <= 1'b0;
            ovf_q  <= 1'b0;
            ld_q   <= 1'b0;
            st_q   <= LS_IDLE;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
            data_q <= data_d;
            idle_q <= idle_d;
            af_q   <= af_d;
            ovf_q  <= ovf_d;
            ld_q   <= ld_d;
            st_q   <= st_d;
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign mem_data    = data_q;
    assign idle        = idle_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign line_done   = ld_q;
endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: scenario tasks plus a randomized run, checked against a queue-based pixel_writer model.
module tb_pixel_writer;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int D  = 16;
    localparam int AW = 19;
`ifdef PIXEL_WRITER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          plot = 1'b0, line_done_in = 1'b0, mem_ack = 1'b0;
    logic [10:0]   x = '0, y = '0;
    logic [7:0]    color = '0;
    logic          mem_req, line_done, idle, almost_full, overflow;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [15:0]   clip_cnt;

    int total = 0;
    int bad   = 0;

    // model: buffered pixels, the output register, sticky flags and the line tracker
    logic [AW-1:0] mq_a[$];
    logic [7:0]    mq_d[$];
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    bit            m_req, m_ovf, m_pend, m_ld;
    int            m_clip;

    always #5 clk = ~clk;

    pixel_writer #(
        .H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .ADDR_W(AW), .COLOR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .plot(plot), .x(x), .y(y), .color(color),
        .line_done_in(line_done_in), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ack(mem_ack), .line_done(line_done), .idle(idle),
        .almost_full(almost_full), .overflow(overflow), .clip_cnt(clip_cnt)
    );

    task automatic model_clear();
        mq_a.delete();
        mq_d.delete();
        m_addr = '0;
        m_data = '0;
        m_req  = 0;
        m_ovf  = 0;
        m_pend = 0;
        m_ld   = 0;
        m_clip = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        plot = 1'b0;
        line_done_in = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // one clock: drive inputs, advance the model, return at the next falling edge
    task automatic cyc(input bit p, input int px, input int py, input int pc, input bit ldi, input bit ack);
        bit take, clipped, acc, idle_post;
        plot = p;
        x = 11'(px);
        y = 11'(py);
        color = 8'(pc);
        line_done_in = ldi;
        mem_ack = ack;
        take    = mq_a.size() > 0 && (!m_req || ack);
        clipped = CLIP && p && (px >= H || py >= V);
        acc     = p && !clipped && (mq_a.size() < D || take);
        if (p && !clipped && !acc) m_ovf = 1;
        if (clipped && m_clip < 65535) m_clip++;
        if (take) begin
            m_addr = mq_a.pop_front();
            m_data = mq_d.pop_front();
            m_req  = 1;
        end else if (ack) m_req = 0;
        if (acc) begin
            mq_a.push_back(AW'(py * H + px));
            mq_d.push_back(8'(pc));
        end
        idle_post = mq_a.size() == 0 && !m_req;
        m_ld   = m_pend && idle_post;
        m_pend = m_pend ? !idle_post : ldi;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        plot = 1'b1;
        x = 11'd5;
        line_done_in = 1'b1;
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", mem_req); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d want=0", mem_addr); end
        total++; if (mem_data !== '0) begin bad++; $display("FAIL reset_data got=%0d want=0", mem_data); end
        total++; if (line_done !== 1'b0) begin bad++; $display("FAIL reset_line_done got=%0b want=0", line_done); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0b want=1", idle); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%0b want=0", almost_full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
        total++; if (clip_cnt !== 16'd0) begin bad++; $display("FAIL reset_clip got=%0d want=0", clip_cnt); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        cyc(1, 3, 2, 8'h5A, 0, 1);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL single_early_req got=%0b want=0", mem_req); end
        cyc(0, 0, 0, 0, 0, 1);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL single_req got=%0b want=1", mem_req); end
        total++; if (mem_addr !== 19'd1283) begin bad++; $display("FAIL single_addr got=%0d want=1283", mem_addr); end
        total++; if (mem_data !== 8'h5A) begin bad++; $display("FAIL single_data got=%0h want=5a", mem_data); end
        cyc(0, 0, 0, 0, 0, 1);
        total++; if (mem_req !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL single_drain req=%0b idle=%0b want req=0 idle=1", mem_req, idle); end
        cyc(0, 0, 0, 0, 1, 1);
        total++; if (line_done !== 1'b0) begin bad++; $display("FAIL single_ld_early got=%0b want=0", line_done); end
        cyc(0, 0, 0, 0, 0, 1);
        total++; if (line_done !== 1'b1) begin bad++; $display("FAIL single_ld got=%0b want=1", line_done); end
        cyc(0, 0, 0, 0, 0, 1);
        total++; if (line_done !== 1'b0) begin bad++; $display("FAIL single_ld_pulse got=%0b want=0", line_done); end
    endtask

    task automatic test_stall_overflow();
        logic [AW-1:0] held;
        bit af_seen = 0;
        do_reset();
        held = '0;
        for (int i = 0; i < 70; i++) begin
            if (i < 40) cyc(1, $urandom_range(0, H-1), $urandom_range(0, V-1), $urandom_range(0, 255), 0, i >= 25);
            else cyc(0, 0, 0, 0, 0, 1);
            if (almost_full) af_seen = 1;
            if (i == 1) held = mem_addr;
            if (i >= 2 && i < 25) begin
                total++; if (mem_req !== 1'b1 || mem_addr !== held) begin bad++; $display("FAIL stall_stable i=%0d req=%0b addr=%0d want req=1 addr=%0d", i, mem_req, mem_addr, held); end
            end
            total++; if (mem_req !== m_req) begin bad++; $display("FAIL stall_req i=%0d got=%0b want=%0b", i, mem_req, m_req); end
            if (m_req) begin
                total++; if (mem_addr !== m_addr || mem_data !== m_data) begin bad++; $display("FAIL stall_addr i=%0d got=%0d/%0h want=%0d/%0h", i, mem_addr, mem_data, m_addr, m_data); end
            end
            total++; if (almost_full !== (mq_a.size() >= D-2)) begin bad++; $display("FAIL stall_af i=%0d got=%0b want=%0b", i, almost_full, mq_a.size() >= D-2); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL stall_ovf i=%0d got=%0b want=%0b", i, overflow, m_ovf); end
        end
        total++; if (!af_seen) begin bad++; $display("FAIL stall_af_rise got=0 want=1"); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL stall_ovf_final got=%0b want=1", overflow); end
    endtask

    task automatic test_clip();
        logic [AW-1:0] got[$];
        logic [AW-1:0] want[$];
        int px[3] = '{639, 640, 0};
        int py[3] = '{479, 0, 480};
        do_reset();
        want.push_back(19'd307199);
        if (!CLIP) begin
            want.push_back(19'd640);
            want.push_back(19'd307200);
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 3) cyc(1, px[i], py[i], i, 0, 1);
            else cyc(0, 0, 0, 0, 0, 1);
            if (mem_req) got.push_back(mem_addr);
        end
        total++; if (got.size() != want.size()) begin bad++; $display("FAIL clip_writes got=%0d want=%0d", got.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            total++; if (got[i] !== want[i]) begin bad++; $display("FAIL clip_addr%0d got=%0d want=%0d", i, got[i], want[i]); end
        end
        total++; if (clip_cnt !== (CLIP ? 16'd2 : 16'd0)) begin bad++; $display("FAIL clip_cnt got=%0d want=%0d", clip_cnt, CLIP ? 2 : 0); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clip_ovf got=%0b want=0", overflow); end
    endtask

    task automatic test_line_merge();
        int acks = 0, ack5_at = -1, pulses = 0, pulse_at = -1;
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 10 + i, 7, i, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        total++; if (line_done !== 1'b0) begin bad++; $display("FAIL merge_ld_stalled got=%0b want=0", line_done); end
        for (int i = 0; i < 15; i++) begin
            if (mem_req) begin
                acks++;
                if (acks == 5) ack5_at = i;
            end
            cyc(0, 0, 0, 0, 0, 1);
            if (line_done) begin
                pulses++;
                pulse_at = i;
            end
            total++; if (line_done !== m_ld) begin bad++; $display("FAIL merge_ld i=%0d got=%0b want=%0b", i, line_done, m_ld); end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL merge_pulses got=%0d want=1", pulses); end
        total++; if (acks != 5 || pulse_at != ack5_at) begin bad++; $display("FAIL merge_timing acks=%0d pulse_at=%0d want acks=5 pulse_at=%0d", acks, pulse_at, ack5_at); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (i < 440)
                cyc($urandom_range(0, 9) < 7, $urandom_range(0, 700), $urandom_range(0, 900), $urandom_range(0, 255),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 9) < (i < 220 ? 8 : 4));
            else cyc(0, 0, 0, 0, 0, 1);
            total++; if (mem_req !== m_req) begin bad++; $display("FAIL rnd_req i=%0d got=%0b want=%0b", i, mem_req, m_req); end
            if (m_req) begin
                total++; if (mem_addr !== m_addr || mem_data !== m_data) begin bad++; $display("FAIL rnd_addr i=%0d got=%0d/%0h want=%0d/%0h", i, mem_addr, mem_data, m_addr, m_data); end
            end
            total++; if (idle !== (mq_a.size() == 0 && !m_req)) begin bad++; $display("FAIL rnd_idle i=%0d got=%0b", i, idle); end
            total++; if (almost_full !== (mq_a.size() >= D-2)) begin bad++; $display("FAIL rnd_af i=%0d got=%0b want=%0b", i, almost_full, mq_a.size() >= D-2); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf i=%0d got=%0b want=%0b", i, overflow, m_ovf); end
            total++; if (line_done !== m_ld) begin bad++; $display("FAIL rnd_ld i=%0d got=%0b want=%0b", i, line_done, m_ld); end
            total++; if (clip_cnt !== 16'(m_clip)) begin bad++; $display("FAIL rnd_clip i=%0d got=%0d want=%0d", i, clip_cnt, m_clip); end
        end
    endtask

    task automatic test_reset_midline();
        bit ld_seen = 0, req_seen = 0;
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, i, 1, i, i == 4, 0);
        total++; if (mem_req !== 1'b1 || mq_a.size() != 4) begin bad++; $display("FAIL rstmid_pre req=%0b queued=%0d want req=1 queued=4", mem_req, mq_a.size()); end
        rst = 1'b1;
        plot = 1'b0;
        line_done_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%0b want=0", mem_req); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%0b want=1", idle); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%0b want=0", overflow); end
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            if (line_done) ld_seen = 1;
            if (mem_req) req_seen = 1;
        end
        total++; if (ld_seen) begin bad++; $display("FAIL rstmid_ld got=1 want=0"); end
        total++; if (req_seen) begin bad++; $display("FAIL rstmid_stale_req got=1 want=0"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_overflow();
        test_clip();
        test_line_merge();
        test_random();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
